// File: rtl/slow_clk_gen.sv
// rtl/slow_clk_gen.sv - integer divider producing the slow clock, edge strobes and a rise counter
// Optional runtime divisor load: define SLOW_CLK_RUNTIME_DIV_EN.
module slow_clk_gen #(
   parameter  int CLK_FREQ_HZ  = 100000000,
   parameter  int SLOW_FREQ_HZ = 1,
   parameter  int TICK_CNT_W   = 8,
   localparam int HALF         = CLK_FREQ_HZ / (2 * SLOW_FREQ_HZ),
   localparam int CNT_W        = (HALF > 1) ? $clog2(HALF) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  restart,
`ifdef SLOW_CLK_RUNTIME_DIV_EN
   input  logic                  div_load,
   input  logic [CNT_W-1:0]      div_half,
`endif
   output logic                  slow_clk,
   output logic                  rise_tick,
   output logic                  fall_tick,
   output logic [TICK_CNT_W-1:0] tick_count
);

   generate
      if (HALF < 1) begin : g_half_check
         $error("slow_clk_gen: CLK_FREQ_HZ/(2*SLOW_FREQ_HZ) must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  slow_clk_q, slow_clk_d;
   logic                  rise_tick_q, rise_tick_d;
   logic                  fall_tick_q, fall_tick_d;
   logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
   logic                  at_term;
   logic                  phase_clear;

`ifdef SLOW_CLK_RUNTIME_DIV_EN
   // One bit wider than cnt so the reset value HALF always fits.
   logic [CNT_W:0] half_q, half_d;
   logic           load_ok;

   always_comb begin
      load_ok     = div_load && (div_half != '0);
      half_d      = load_ok ? {1'b0, div_half} : half_q;
      at_term     = ({1'b0, cnt_q} == (half_q - (CNT_W+1)'(1)));
      phase_clear = restart || load_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         half_q <= (CNT_W+1)'(HALF);
      end else begin
         half_q <= half_d;
      end
   end
`else
   localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

   always_comb begin
      at_term     = (cnt_q == TERM);
      phase_clear = restart;
   end
`endif

   always_comb begin
      cnt_d        = cnt_q;
      slow_clk_d   = slow_clk_q;
      rise_tick_d  = 1'b0;
      fall_tick_d  = 1'b0;
      tick_count_d = tick_count_q;
      if (phase_clear) begin
         cnt_d        = '0;
         slow_clk_d   = 1'b0;
         tick_count_d = '0;
      end else if (en) begin
         if (at_term) begin
            cnt_d      = '0;
            slow_clk_d = ~slow_clk_q;
            if (!slow_clk_q) begin
               rise_tick_d  = 1'b1;
               tick_count_d = tick_count_q + TICK_CNT_W'(1);
            end else begin
               fall_tick_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         slow_clk_q   <= 1'b0;
         rise_tick_q  <= 1'b0;
         fall_tick_q  <= 1'b0;
         tick_count_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         slow_clk_q   <= slow_clk_d;
         rise_tick_q  <= rise_tick_d;
         fall_tick_q  <= fall_tick_d;
         tick_count_q <= tick_count_d;
      end
   end

   assign slow_clk   = slow_clk_q;
   assign rise_tick  = rise_tick_q;
   assign fall_tick  = fall_tick_q;
   assign tick_count = tick_count_q;

endmodule

// File: tb/tb_slow_clk_gen.sv
// tb/tb_slow_clk_gen.sv - directed bench for slow_clk_gen (HALF=5 and HALF=1 instances)
// Runtime divisor scenario is included when SLOW_CLK_RUNTIME_DIV_EN is defined.
module tb_slow_clk_gen;

   logic       clk = 1'b0;
   logic       rst, en, restart;
   logic       slow_clk, rise_tick, fall_tick;
   logic [7:0] tick_count;
   logic       rst1, en1, restart1;
   logic       slow_clk1, rise_tick1, fall_tick1;
   logic [1:0] tick_count1;
`ifdef SLOW_CLK_RUNTIME_DIV_EN
   logic       div_load;
   logic [2:0] div_half;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   slow_clk_gen #(.CLK_FREQ_HZ(10), .SLOW_FREQ_HZ(1), .TICK_CNT_W(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .restart    (restart),
`ifdef SLOW_CLK_RUNTIME_DIV_EN
      .div_load   (div_load),
      .div_half   (div_half),
`endif
      .slow_clk   (slow_clk),
      .rise_tick  (rise_tick),
      .fall_tick  (fall_tick),
      .tick_count (tick_count)
   );

   slow_clk_gen #(.CLK_FREQ_HZ(2), .SLOW_FREQ_HZ(1), .TICK_CNT_W(2)) u_dut1 (
      .clk        (clk),
      .rst        (rst1),
      .en         (en1),
      .restart    (restart1),
`ifdef SLOW_CLK_RUNTIME_DIV_EN
      .div_load   (1'b0),
      .div_half   (1'b0),
`endif
      .slow_clk   (slow_clk1),
      .rise_tick  (rise_tick1),
      .fall_tick  (fall_tick1),
      .tick_count (tick_count1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic s, input logic r, input logic f, input logic [7:0] t);
      check({tag, " slow_clk"}, {31'd0, slow_clk}, {31'd0, s});
      check({tag, " rise_tick"}, {31'd0, rise_tick}, {31'd0, r});
      check({tag, " fall_tick"}, {31'd0, fall_tick}, {31'd0, f});
      check({tag, " tick_count"}, {24'd0, tick_count}, {24'd0, t});
   endtask

   // HALF=5 from phase zero: rise on edge 5, fall on edge 10, period 10.
   task automatic run_nominal(input string tag, input int n);
      for (int k = 1; k <= n; k++) begin
         step();
         check_outs($sformatf("%s k=%0d", tag, k), ((k / 5) % 2) == 1,
                    (k % 10) == 5, (k % 10) == 0, 8'((k + 5) / 10));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; restart = 1'b0;
      rst1 = 1'b1; en1 = 1'b0; restart1 = 1'b0;
`ifdef SLOW_CLK_RUNTIME_DIV_EN
      div_load = 1'b0; div_half = 3'd0;
`endif
      step();
      step();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);

      // nominal run, 30 enabled edges
      rst = 1'b0; en = 1'b1;
      run_nominal("nominal", 30);
      check("nominal tick_count after 30", {24'd0, tick_count}, 32'd3);

      // enable drop at cnt=2 stretches the half-period by 3
      step();
      step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("frozen %0d", i), 1'b0, 1'b0, 1'b0, 8'd3);
      end
      en = 1'b1;
      step();
      step();
      check_outs("resume pre-rise", 1'b0, 1'b0, 1'b0, 8'd3);
      step();
      check_outs("resume rise", 1'b1, 1'b1, 1'b0, 8'd4);

      // restart while high with tick_count=4
      step();
      step();
      restart = 1'b1;
      step();
      check_outs("restart", 1'b0, 1'b0, 1'b0, 8'd0);
      restart = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check_outs($sformatf("post-restart %0d", i), 1'b0, 1'b0, 1'b0, 8'd0);
      end
      step();
      check_outs("post-restart rise", 1'b1, 1'b1, 1'b0, 8'd1);

      // rst wins over restart and en mid half-period
      step();
      step();
      rst = 1'b1; restart = 1'b1; en = 1'b1;
      step();
      check_outs("rst priority", 1'b0, 1'b0, 1'b0, 8'd0);
      rst = 1'b0; restart = 1'b0;
      run_nominal("after rst", 12);

      // HALF=1, 2-bit counter: toggles every cycle, rises give 1,2,3,0,1
      step();
      rst1 = 1'b0; en1 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         check($sformatf("half1 k=%0d slow_clk", k), {31'd0, slow_clk1}, 32'(k % 2));
         check($sformatf("half1 k=%0d rise_tick", k), {31'd0, rise_tick1}, 32'(k % 2));
         check($sformatf("half1 k=%0d fall_tick", k), {31'd0, fall_tick1}, 32'((k + 1) % 2));
         check($sformatf("half1 k=%0d tick_count", k), {30'd0, tick_count1}, 32'(((k + 1) / 2) % 4));
      end

`ifdef SLOW_CLK_RUNTIME_DIV_EN
      // load half=2 restarts; later zero load is ignored
      step();
      step();
      div_load = 1'b1; div_half = 3'd2;
      step();
      check_outs("load restart", 1'b0, 1'b0, 1'b0, 8'd0);
      div_load = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 9) begin
            div_load = 1'b1; div_half = 3'd0;
         end
         step();
         div_load = 1'b0;
         check_outs($sformatf("div2 k=%0d", k), ((k / 2) % 2) == 1,
                    (k % 4) == 2, (k % 4) == 0, 8'((k + 2) / 4));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
